// File: rtl/reg_bank_wr.sv
// reg_bank_wr: 32 x DATA_W register bank, two async read ports, one sync write.
// Optional same-cycle write forwarding when REG_BANK_BYPASS_EN is defined.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   reg_write    write enable
//   write_reg    destination index (rt, rd, 29 or 31 from the write mux)
//   write_data   value stored verbatim
//   read_reg1/2  read indices (rs, rt)
//   read_data1/2 combinational read data; index 0 always reads 0
//   sp_out       contents of register SP_IDX
//   wr_ra_pulse  one-cycle pulse after each committed write to RA_IDX
//
// Macro REG_BANK_BYPASS_EN: reads (and sp_out) see write_data in the
// same cycle as a matching write. Undefined: old value until the edge.

module reg_bank_wr #(
    parameter int DATA_W  = 32,
    parameter int SP_IDX  = 29,
    parameter int SP_INIT = 227,
    parameter int RA_IDX  = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [4:0]        write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [4:0]        read_reg1,
    input  logic [4:0]        read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic [DATA_W-1:0] sp_out,
    output logic              wr_ra_pulse
);

    localparam logic [4:0] SP = 5'(SP_IDX);
    localparam logic [4:0] RA = 5'(RA_IDX);

    logic [DATA_W-1:0] mem [32];
    logic              wen;
    logic              hit1;
    logic              hit2;
    logic              hitsp;

    // Writes to index 0 never commit, so the zero register stays clean.
    assign wen = reg_write && (write_reg != 5'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] <= (i == SP_IDX) ? DATA_W'(SP_INIT) : '0;
            end
            wr_ra_pulse <= 1'b0;
        end else begin
            if (wen) begin
                mem[write_reg] <= write_data;
            end
            wr_ra_pulse <= wen && (write_reg == RA);
        end
    end

`ifdef REG_BANK_BYPASS_EN
    assign hit1  = wen && (read_reg1 == write_reg);
    assign hit2  = wen && (read_reg2 == write_reg);
    assign hitsp = wen && (write_reg == SP);
`else
    assign hit1  = 1'b0;
    assign hit2  = 1'b0;
    assign hitsp = 1'b0;
`endif

    // Index 0 check comes first so forwarding can never leak into r0.
    assign read_data1 = (read_reg1 == 5'd0) ? '0 :
                        hit1 ? write_data : mem[read_reg1];
    assign read_data2 = (read_reg2 == 5'd0) ? '0 :
                        hit2 ? write_data : mem[read_reg2];
    assign sp_out     = hitsp ? write_data : mem[SP];

endmodule
